systolic_skew_feeder: RTL and testbench

//  Transmit side of the systolic_array 'a' input interface. Accepts matrix A
//  one column per beat and emits the diagonally skewed per-lane vectors the

---
 rtl/systolic_skew_feeder.sv | 85 ++++++++
 tb/tb_systolic_skew_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: accepts matrix A column by column and emits diagonally skewed lanes plus step enable for systolic_array
module systolic_skew_feeder #(
  parameter int N_MAX  = 16,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [5:0]              matrix_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_MAX*DATA_W-1:0] col_in,
  output logic [N_MAX*DATA_W-1:0] a_out,
  output logic                    arr_en,
  output logic                    busy,
  output logic                    done
);
  localparam int NW = $clog2(N_MAX + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] nr_q, nr_d, cnt_q, cnt_d;
  logic fin_q, fin_d, done_q, arr_en_q, go, adv;
  always_comb begin
    go = state_q == IDLE && !fin_q && start && matrix_N != 6'd0;
    adv = (state_q == FEED && in_valid) || state_q == DRAIN;
    state_d = state_q;
    nr_d = nr_q;
    cnt_d = cnt_q;
    fin_d = 1'b0;
    if (go) begin
      state_d = FEED;
      nr_d = matrix_N > 6'(N_MAX) ? NW'(N_MAX) : NW'(matrix_N);
      cnt_d = '0;
    end else if (state_q == FEED && in_valid) begin
      cnt_d = cnt_q == nr_q - NW'(1) ? '0 : cnt_q + NW'(1);
      state_d = cnt_q != nr_q - NW'(1) ? FEED : nr_q == NW'(1) ? IDLE : DRAIN;
      fin_d = cnt_q == nr_q - NW'(1) && nr_q == NW'(1);
    end else if (state_q == DRAIN) begin
      fin_d = cnt_q == nr_q - NW'(2);
      cnt_d = fin_d ? '0 : cnt_q + NW'(1);
      state_d = fin_d ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      nr_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
      done_q <= 1'b0;
      arr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nr_q <= nr_d;
      cnt_q <= cnt_d;
      fin_q <= fin_d;
      done_q <= fin_q;
      arr_en_q <= adv;
    end
  end
  for (genvar i = 0; i < N_MAX; i++) begin : g_lane
    logic [DATA_W-1:0] sr_q [i+1];
    logic [DATA_W-1:0] sr_d [i+1];
    logic [DATA_W-1:0] din;
    assign din = state_q == FEED && NW'(i) < nr_q ? col_in[i*DATA_W +: DATA_W] : '0;
    always_comb begin
      sr_d = sr_q;
      if (go) begin
        sr_d = '{default: '0};
      end else if (adv) begin
        sr_d[0] = din;
        for (int j = 1; j <= i; j++) sr_d[j] = sr_q[j-1];
      end
    end
    always_ff @(posedge clk) begin
      if (!reset_n) sr_q <= '{default: '0};
      else sr_q <= sr_d;
    end
    assign a_out[i*DATA_W +: DATA_W] = sr_q[i];
  end
  assign in_ready = state_q == FEED;
  assign arr_en = arr_en_q;
  assign busy = state_q != IDLE || fin_q;
  assign done = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: scoreboard bench comparing skewed lane output against a matrix-level model
module tb_systolic_skew_feeder;
  localparam int N = 16;
  localparam int W = 16;
  typedef struct packed {
    logic [N*W-1:0] v;
    logic           last;
  } step_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] matrix_N = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N*W-1:0] col_in = '0;
  logic [N*W-1:0] a_out;
  logic arr_en, busy, done;
  int total = 0;
  int bad = 0;
  step_t sb[$];
  step_t e;
  logic pend_done = 1'b0;
  logic pd;
  logic prev_busy = 1'b0;
  logic [N*W-1:0] prev_a = '0;
  logic [W-1:0] am [N][N];
  systolic_skew_feeder #(.N_MAX(N), .DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .matrix_N(matrix_N),
    .in_valid(in_valid), .in_ready(in_ready), .col_in(col_in),
    .a_out(a_out), .arr_en(arr_en), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset_n) begin
      pd = 1'b0;
      if (arr_en) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL step: unexpected arr_en, a_out=%h required no step", a_out);
        end else begin
          e = sb.pop_front();
          if (a_out !== e.v) begin
            bad++;
            $display("FAIL step: a_out=%h required %h", a_out, e.v);
          end
          pd = e.last;
        end
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_step: busy=%b required 1", busy);
        end
      end else if (busy && prev_busy) begin
        total++;
        if (a_out !== prev_a) begin
          bad++;
          $display("FAIL hold: a_out=%h required %h", a_out, prev_a);
        end
      end
      total++;
      if (done !== pend_done) begin
        bad++;
        $display("FAIL done: done=%b required %b", done, pend_done);
      end
      if (pend_done) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_done: busy=%b required 0", busy);
        end
      end
      pend_done = pd;
      prev_busy = busy;
      prev_a = a_out;
    end
  end
  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [N*W-1:0] junk();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction
  function automatic logic [N*W-1:0] column(input int k);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = am[i][k];
    return v;
  endfunction
  task automatic fill(input int mode);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        am[i][k] = mode == 1 ? (i == 3 ? 16'h4000 : i < 3 ? 16'h3C00 : W'($urandom)) :
                   mode == 2 && i >= 2 ? 16'hFFFF : W'($urandom);
  endtask
  task automatic start_run(input int mn, output int nr);
    logic [N*W-1:0] v;
    step_t s;
    nr = mn > N ? N : mn;
    for (int st = 0; st <= 2 * nr - 2; st++) begin
      v = '0;
      for (int i = 0; i < nr; i++)
        if (st - i >= 0 && st - i < nr) v[i*W +: W] = am[i][st-i];
      s.v = v;
      s.last = st == 2 * nr - 2;
      sb.push_back(s);
    end
    start = 1'b1;
    matrix_N = 6'(mn);
    cyc();
    start = 1'b0;
    matrix_N = 6'($urandom);
  endtask
  task automatic feed(input int nr, input int stall_at, input int stall_len, input bit poke);
    for (int k = 0; k < nr; k++) begin
      if (k == stall_at)
        repeat (stall_len) begin
          in_valid = 1'b0;
          col_in = junk();
          cyc();
        end
      in_valid = 1'b1;
      col_in = column(k);
      start = poke && k == 1;
      matrix_N = 6'd7;
      chk("in_ready_feed", N*W'(in_ready), N*W'(1));
      cyc();
      start = 1'b0;
    end
    in_valid = 1'($urandom);
    col_in = junk();
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done || sb.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    in_valid = 1'b0;
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL timeout: busy=%b pending=%0d required idle", busy, sb.size());
    end
    chk("in_ready_idle", N*W'(in_ready), '0);
  endtask
  task automatic run(input int mn, input int mode, input int stall_at, input int stall_len);
    int nr;
    fill(mode);
    start_run(mn, nr);
    feed(nr, stall_at, stall_len, 1'b0);
    wait_idle();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nr, n, mn;
    cyc();
    cyc();
    chk("reset_a_out", a_out, '0);
    chk("reset_ctrl", N*W'({arr_en, busy, done, in_ready}), '0);
    reset_n = 1'b1;
    cyc();
    run(4, 1, 99, 0);
    run(4, 1, 2, 2);
    run(2, 2, 99, 0);
    start = 1'b1;
    matrix_N = 6'd0;
    cyc();
    start = 1'b0;
    repeat (4) begin
      chk("busy_n0", N*W'(busy), '0);
      cyc();
    end
    run(40, 0, 99, 0);
    fill(1);
    start_run(4, nr);
    feed(nr, 99, 0, 1'b0);
    cyc();
    reset_n = 1'b0;
    sb.delete();
    pend_done = 1'b0;
    prev_busy = 1'b0;
    cyc();
    chk("abort_a_out", a_out, '0);
    chk("abort_ctrl", N*W'({arr_en, busy, done, in_ready}), '0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    repeat (6) cyc();
    run(4, 1, 99, 0);
    fill(0);
    start_run(5, nr);
    feed(nr, 3, 1, 1'b1);
    n = 0;
    while (!done && n < 100) begin
      cyc();
      n++;
    end
    in_valid = 1'b0;
    chk("done_seen", N*W'(done), N*W'(1));
    fill(0);
    start_run(3, nr);
    chk("in_ready_after_done", N*W'(in_ready), N*W'(1));
    feed(nr, 99, 0, 1'b0);
    wait_idle();
    run(1, 0, 99, 0);
    repeat (8) begin
      mn = $urandom_range(1, 20);
      nr = mn > N ? N : mn;
      run(mn, 0, $urandom_range(0, nr), $urandom_range(1, 3));
    end
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
